// File: rtl/rob_retire.sv
// Reorder buffer: tracks renamed instructions in program order and retires up to
// COMMIT_WIDTH completed entries per cycle from the head.
module rob_retire #(
    parameter int ROB_DEPTH    = 16,
    parameter int FETCH_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int WB_WIDTH     = 2,
    parameter int CREG_W       = 5,
    parameter int PREG_W       = 6,
    parameter int IDX_W        = $clog2(ROB_DEPTH)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic [FETCH_WIDTH-1:0]         alloc_valid,
    input  logic [FETCH_WIDTH*CREG_W-1:0]  alloc_dst,
    input  logic [FETCH_WIDTH*PREG_W-1:0]  alloc_preg,
    output logic                           alloc_ready,
    output logic [FETCH_WIDTH*IDX_W-1:0]   alloc_idx,
    input  logic [WB_WIDTH-1:0]            wb_valid,
    input  logic [WB_WIDTH*IDX_W-1:0]      wb_idx,
    output logic [COMMIT_WIDTH-1:0]        retire_valid,
    output logic [COMMIT_WIDTH*CREG_W-1:0] retire_dst,
    output logic [COMMIT_WIDTH*PREG_W-1:0] retire_preg,
    output logic [IDX_W:0]                 count
);

    localparam logic [IDX_W:0] ALLOC_LIMIT = (IDX_W+1)'(ROB_DEPTH - FETCH_WIDTH);

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] done_q;
    logic [CREG_W-1:0]    dst_q  [ROB_DEPTH];
    logic [PREG_W-1:0]    preg_q [ROB_DEPTH];
    logic [IDX_W-1:0]     head_q;
    logic [IDX_W-1:0]     tail_q;
    logic [IDX_W:0]       count_q;
    logic [IDX_W:0]       count_d;

    logic [IDX_W-1:0]     slot_idx [FETCH_WIDTH];
    logic [IDX_W-1:0]     ret_idx  [COMMIT_WIDTH];
    logic [IDX_W:0]       alloc_n;
    logic [IDX_W:0]       ret_n;
    logic                 alloc_fire;
    logic                 ret_chain;
    logic                 clear;

    assign clear       = reset || flush;
    assign alloc_ready = (count_q <= ALLOC_LIMIT);
    assign count       = count_q;

    // Valid slots are packed: each slot's index is tail plus the valid slots before it.
    always_comb begin
        alloc_n   = '0;
        alloc_idx = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            slot_idx[i] = tail_q + alloc_n[IDX_W-1:0];
            alloc_idx[i*IDX_W +: IDX_W] = slot_idx[i];
            alloc_n = alloc_n + (IDX_W+1)'(alloc_valid[i]);
        end
        alloc_fire = alloc_ready && (|alloc_valid) && !clear;
    end

    always_comb begin
        ret_chain    = 1'b1;
        ret_n        = '0;
        retire_valid = '0;
        retire_dst   = '0;
        retire_preg  = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            ret_idx[k] = head_q + IDX_W'(k);
            ret_chain  = ret_chain && valid_q[ret_idx[k]] && done_q[ret_idx[k]] && !clear;
            if (ret_chain) begin
                retire_valid[k]                 = 1'b1;
                retire_dst[k*CREG_W +: CREG_W]  = dst_q[ret_idx[k]];
                retire_preg[k*PREG_W +: PREG_W] = preg_q[ret_idx[k]];
                ret_n = ret_n + (IDX_W+1)'(1);
            end
        end
        count_d = count_q + (alloc_fire ? alloc_n : '0) - ret_n;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: several non-blocking writes may hit one bit here; the last one wins,
            // so a fresh allocation's done=0 overrides any stray writeback to that slot.
            for (int w = 0; w < WB_WIDTH; w++) begin
                if (wb_valid[w] && valid_q[wb_idx[w*IDX_W +: IDX_W]])
                    done_q[wb_idx[w*IDX_W +: IDX_W]] <= 1'b1;
            end
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (retire_valid[k]) begin
                    valid_q[ret_idx[k]] <= 1'b0;
                    done_q[ret_idx[k]]  <= 1'b0;
                end
            end
            if (alloc_fire) begin
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        valid_q[slot_idx[i]] <= 1'b1;
                        done_q[slot_idx[i]]  <= 1'b0;
                    end
                end
                tail_q <= tail_q + alloc_n[IDX_W-1:0];
            end
            head_q  <= head_q + ret_n[IDX_W-1:0];
            count_q <= count_d;
        end
    end

    // NOTE: payload arrays have no reset; every read is gated by valid_q/done_q.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (alloc_valid[i]) begin
                    dst_q[slot_idx[i]]  <= alloc_dst[i*CREG_W +: CREG_W];
                    preg_q[slot_idx[i]] <= alloc_preg[i*PREG_W +: PREG_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire with an in-order scoreboard of allocated entries
// that is popped and compared whenever the DUT retires.
module tb_rob_retire;

    localparam int D  = 16;
    localparam int FW = 2;
    localparam int CW = 2;
    localparam int WW = 2;
    localparam int CR = 5;
    localparam int PR = 6;
    localparam int IW = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CR-1:0] dst;
        logic [PR-1:0] preg;
    } ent_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [FW-1:0]    alloc_valid;
    logic [FW*CR-1:0] alloc_dst;
    logic [FW*PR-1:0] alloc_preg;
    logic             alloc_ready;
    logic [FW*IW-1:0] alloc_idx;
    logic [WW-1:0]    wb_valid;
    logic [WW*IW-1:0] wb_idx;
    logic [CW-1:0]    retire_valid;
    logic [CW*CR-1:0] retire_dst;
    logic [CW*PR-1:0] retire_preg;
    logic [IW:0]      count;

    int            total   = 0;
    int            passed  = 0;
    int            fails   = 0;
    int            retired = 0;
    ent_t          q[$];
    logic [IW-1:0] exp_tail;

    always #5 clk = ~clk;

    rob_retire #(
        .ROB_DEPTH(D), .FETCH_WIDTH(FW), .COMMIT_WIDTH(CW), .WB_WIDTH(WW),
        .CREG_W(CR), .PREG_W(PR), .IDX_W(IW)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_preg(alloc_preg),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx),
        .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_preg(retire_preg),
        .count(count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic alloc2(input logic [1:0] v, input logic [CR-1:0] d0, input logic [PR-1:0] p0,
                          input logic [CR-1:0] d1, input logic [PR-1:0] p1);
        alloc_valid = v;
        alloc_dst   = {d1, d0};
        alloc_preg  = {p1, p0};
    endtask

    task automatic wb2(input logic [1:0] v, input logic [IW-1:0] i0, input logic [IW-1:0] i1);
        wb_valid = v;
        wb_idx   = {i1, i0};
    endtask

    // One clock cycle: compare retire outputs against the scoreboard, record accepted
    // allocations, then advance past the edge and idle the inputs.
    task automatic cycle();
        bit   ready_exp;
        ent_t e;
        #1;
        ready_exp = (q.size() <= D - FW);
        check("count", 32'(count), 32'(q.size()));
        check("alloc_ready", 32'(alloc_ready), 32'(ready_exp));
        check("retire_prefix", 32'(retire_valid & (retire_valid + 2'd1)), 32'd0);
        if (flush) check("retire_in_flush", 32'(retire_valid), 32'd0);
        for (int k = 0; k < CW; k++) begin
            if (retire_valid[k]) begin
                if (q.size() == 0) begin
                    check("retire_when_empty", 32'(retire_valid[k]), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("retire_dst", 32'(retire_dst[k*CR +: CR]), 32'(e.dst));
                    check("retire_preg", 32'(retire_preg[k*PR +: PR]), 32'(e.preg));
                    retired++;
                end
            end else begin
                check("retire_dst_zero", 32'(retire_dst[k*CR +: CR]), 32'd0);
                check("retire_preg_zero", 32'(retire_preg[k*PR +: PR]), 32'd0);
            end
        end
        if (ready_exp && (|alloc_valid) && !flush) begin
            for (int i = 0; i < FW; i++) begin
                if (alloc_valid[i]) begin
                    check("alloc_idx", 32'(alloc_idx[i*IW +: IW]), 32'(exp_tail));
                    e.idx  = exp_tail;
                    e.dst  = alloc_dst[i*CR +: CR];
                    e.preg = alloc_preg[i*PR +: PR];
                    q.push_back(e);
                    exp_tail = exp_tail + 4'd1;
                end
            end
        end
        if (flush) begin
            q.delete();
            exp_tail = '0;
        end
        @(posedge clk);
        #1;
        alloc_valid = '0;
        wb_valid    = '0;
        flush       = 1'b0;
    endtask

    task automatic wb_all();
        logic [IW-1:0] l[$];
        int n;
        foreach (q[j]) l.push_back(q[j].idx);
        n = l.size();
        for (int j = 0; j < n; j += 2) begin
            if (j + 1 < n) wb2(2'b11, l[j], l[j+1]);
            else           wb2(2'b01, l[j], l[j]);
            cycle();
        end
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 40 && q.size() > 0; n++) cycle();
        #1;
        check(tag, 32'(count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] wbl[$];
        logic [IW-1:0] pa [20];
        logic [IW-1:0] pb [20];
        logic [1:0]    v;
        logic [IW-1:0] i0, i1;
        int            start;

        reset = 1'b1; flush = 1'b0;
        alloc_valid = '0; alloc_dst = '0; alloc_preg = '0;
        wb_valid = '0; wb_idx = '0; exp_tail = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_retire_valid", 32'(retire_valid), 32'd0);
        check("rst_retire_dst", 32'(retire_dst), 32'd0);
        check("rst_retire_preg", 32'(retire_preg), 32'd0);

        // Basic in-order retire after out-of-order completion
        alloc2(2'b11, 5'd3, 6'd10, 5'd4, 6'd11);
        #1;
        check("t1_idx0", 32'(alloc_idx[3:0]), 32'd0);
        check("t1_idx1", 32'(alloc_idx[7:4]), 32'd1);
        cycle();
        wb2(2'b10, 4'd0, 4'd1);
        #1 check("t1_no_retire_a", 32'(retire_valid), 32'd0);
        cycle();
        wb2(2'b01, 4'd0, 4'd0);
        #1 check("t1_no_retire_b", 32'(retire_valid), 32'd0);
        cycle();
        #1;
        check("t1_retire_both", 32'(retire_valid), 32'd3);
        check("t1_dst0", 32'(retire_dst[4:0]), 32'd3);
        check("t1_preg0", 32'(retire_preg[5:0]), 32'd10);
        check("t1_dst1", 32'(retire_dst[9:5]), 32'd4);
        check("t1_preg1", 32'(retire_preg[11:6]), 32'd11);
        cycle();
        #1 check("t1_count_zero", 32'(count), 32'd0);

        // Fill to full, hold a request, then drain two per cycle
        for (int c = 0; c < 8; c++) begin
            alloc2(2'b11, 5'(2*c+1), 6'(2*c+20), 5'(2*c+2), 6'(2*c+21));
            cycle();
        end
        alloc2(2'b11, 5'd9, 6'd9, 5'd9, 6'd9);
        #1;
        check("t2_full_ready", 32'(alloc_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd16);
        cycle();
        foreach (q[j]) wbl.push_back(q[j].idx);
        for (int c = 0; c < 8; c++) begin
            wb2(2'b11, wbl[2*c], wbl[2*c+1]);
            if (c == 0) begin
                alloc2(2'b01, 5'd1, 6'd1, 5'd0, 6'd0);
                #1 check("t2_tail_held", 32'(alloc_idx[3:0]), 32'd2);
            end
            if (c > 0) begin
                #1 check("t2_retire_pair", 32'(retire_valid), 32'd3);
            end
            if (c == 2) begin
                check("t2_count_14", 32'(count), 32'd14);
                check("t2_ready_at_14", 32'(alloc_ready), 32'd1);
            end
            cycle();
        end
        drain("t2_drained");

        // Sparse group starting at tail 5
        alloc2(2'b11, 5'd1, 6'd1, 5'd2, 6'd2);
        cycle();
        alloc2(2'b01, 5'd3, 6'd3, 5'd0, 6'd0);
        cycle();
        alloc2(2'b10, 5'd0, 6'd0, 5'd7, 6'd33);
        #1 check("t3_sparse_idx", 32'(alloc_idx[7:4]), 32'd5);
        cycle();
        alloc2(2'b11, 5'd8, 6'd34, 5'd9, 6'd35);
        #1;
        check("t3_count", 32'(count), 32'd4);
        check("t3_idx0", 32'(alloc_idx[3:0]), 32'd6);
        check("t3_idx1", 32'(alloc_idx[7:4]), 32'd7);
        cycle();
        wb_all();
        drain("t3_drained");

        // Stream 40 instructions across the wrap, younger of each pair completing first
        start = retired;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                pa[c] = exp_tail;
                pb[c] = exp_tail + 4'd1;
                alloc2(2'b11, 5'(2*c), 6'(2*c), 5'(2*c+1), 6'(2*c+1));
            end
            v = 2'b00; i0 = '0; i1 = '0;
            if (c >= 1 && c <= 20) begin v[0] = 1'b1; i0 = pb[c-1]; end
            if (c >= 2 && c <= 21) begin v[1] = 1'b1; i1 = pa[c-2]; end
            wb2(v, i0, i1);
            cycle();
        end
        drain("t4_drained");
        check("t4_retired", 32'(retired - start), 32'd40);

        // Flush with five entries outstanding and a retire/wb/alloc pending
        alloc2(2'b11, 5'd11, 6'd51, 5'd12, 6'd52);
        cycle();
        alloc2(2'b11, 5'd13, 6'd53, 5'd14, 6'd54);
        cycle();
        alloc2(2'b01, 5'd15, 6'd55, 5'd0, 6'd0);
        wb2(2'b01, q[0].idx, q[0].idx);
        cycle();
        flush = 1'b1;
        wb2(2'b01, q[1].idx, q[1].idx);
        alloc2(2'b11, 5'd16, 6'd56, 5'd17, 6'd57);
        #1;
        check("t5_flush_retire", 32'(retire_valid), 32'd0);
        check("t5_count_pre", 32'(count), 32'd5);
        cycle();
        #1 check("t5_count_post", 32'(count), 32'd0);
        alloc2(2'b11, 5'd18, 6'd58, 5'd19, 6'd59);
        #1;
        check("t5_idx0", 32'(alloc_idx[3:0]), 32'd0);
        check("t5_idx1", 32'(alloc_idx[7:4]), 32'd1);
        cycle();
        #1 check("t5_no_stale_done", 32'(retire_valid), 32'd0);
        wb_all();
        drain("t5_drained");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rob_retire.md
# rob_retire

Reorder buffer that tracks renamed instructions in program order and produces the per-cycle retire stream consumed by the rename-side alias table and free list. Rename pushes up to FETCH_WIDTH instructions per cycle, each carrying its architectural destination and newly allocated physical register. Execution writeback marks entries complete. The block retires up to COMMIT_WIDTH completed instructions per cycle, strictly from the head, driving `retire_valid/dst/preg` as the transmitting end of the retire interface.

## Interface
- ROB_DEPTH, 16, entry count; power of two, at least FETCH_WIDTH
- FETCH_WIDTH, 2, rename slots per cycle
- COMMIT_WIDTH, 2, retire slots per cycle
- WB_WIDTH, 2, writeback ports
- CREG_W, 5, architectural register index width
- PREG_W, 6, physical register index width
- IDX_W, $clog2(ROB_DEPTH), ROB index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard all entries
- alloc_valid  in  FETCH_WIDTH  per-slot rename request
- alloc_dst  in  FETCH_WIDTH*CREG_W  architectural destination per slot
- alloc_preg  in  FETCH_WIDTH*PREG_W  physical register per slot
- alloc_ready  out  1  the whole rename group is accepted this cycle
- alloc_idx  out  FETCH_WIDTH*IDX_W  ROB index assigned to each slot
- wb_valid  in  WB_WIDTH  completion strobe
- wb_idx  in  WB_WIDTH*IDX_W  ROB index completing
- retire_valid  out  COMMIT_WIDTH  retire slot i valid; set bits form a contiguous prefix starting at bit 0
- retire_dst  out  COMMIT_WIDTH*CREG_W  architectural destination
- retire_preg  out  COMMIT_WIDTH*PREG_W  physical register
- count  out  IDX_W+1  occupied entries

## Operation
- State consists of entry arrays {valid, done, dst, preg}, the `head` and `tail` registers (IDX_W bits, wrap modulo ROB_DEPTH), and the `count` register.
- `alloc_ready` = (count <= ROB_DEPTH - FETCH_WIDTH). It is computed from registered count only. Same-cycle retires are not credited.
- Allocation:
  - Accepted when alloc_ready && |alloc_valid && !flush.
  - Valid slots are packed: slot i gets index tail + popcount(alloc_valid[i-1:0]).
  - `alloc_idx` for an invalid slot is don't-care.
  - Each accepted entry is written with valid=1, done=0, dst, preg.
  - tail and count advance by popcount(alloc_valid).
  - When alloc_ready=0, the block writes nothing. Rename holds the group.
- Writeback:
  - Each wb_valid sets done at wb_idx.
  - A writeback to an entry whose valid=0 is ignored.
  - Duplicate indices across ports are harmless.
- Retire:
  - retire_valid[k]=1 iff entries head..head+k are all valid && done, and retire_valid[k-1]=1.
  - dst and preg come from entry head+k.
  - When retire_valid[k]=0, retire_dst and retire_preg for that slot are 0.
  - Retired entries are cleared (valid=0, done=0) at the edge. head advances by the retire count.
- count_next = count + allocated - retired.
- dst=0 entries are allocated and retired normally. The consumer decides whether to ignore them.
- Flush:
  - All valid and done bits clear, head=tail=count=0.
  - retire_valid forced 0 in the flush cycle.
  - Alloc and wb in the flush cycle are dropped.
- Reset behaves identically to flush. All outputs are 0 after reset except alloc_ready=1.

## Timing
- Retire outputs are combinational from registered state. Retirement commits at the next clk edge.
- Writeback-to-retire latency: at least 1 cycle. A wb at edge N makes the entry eligible in cycle N+1.
- Alloc-to-retire latency: at least 2 cycles (alloc edge, then wb edge, then retire cycle).
- alloc_idx is combinational from tail and alloc_valid, and is valid in the request cycle.
- Simultaneous alloc and retire in one cycle are both applied. Count remains exact.
- A writeback to an index allocated in the same cycle is illegal and is ignored.
- Full boundary: at count=ROB_DEPTH, alloc_ready=0, and retire still proceeds.
- Empty boundary: at count=0, retire_valid=0.
- Pointer wrap: indices wrap from ROB_DEPTH-1 to 0 with order preserved.

## Test plan
- Reset → count=0, alloc_ready=1, retire_valid=0, retire_dst/preg=0.
- Allocate {dst3/preg10, dst4/preg11} → alloc_idx 0,1. Then wb idx1 only → no retire. Then wb idx0 → the next cycle has retire_valid=2'b11 with (3,10),(4,11) in order, and count becomes 0 after the edge.
- Allocate 2 per cycle for 8 cycles → count=16, alloc_ready=0 from count 15 onward. A 9th request is not written (tail unchanged). Then wb all → 2 retires/cycle, and alloc_ready returns when count=14.
- Sparse alloc_valid=2'b10 with tail=5 → slot1 gets idx 5, count+1. The next full group gets idx 6,7.
- Stream 40 instructions with wb in reverse pairs → indices wrap past 15→0, and the retire order matches allocation order exactly.
- Five entries outstanding with a wb pending in the same cycle as flush → retire_valid=0 that cycle. The next cycle has count=0, and the next alloc gets idx 0.
